// File: rtl/clock_period_meter.sv
// Recovers the max value of a clock divider by timing the half-period of its output
// (sig_i) in clk_i cycles; reports lock when consecutive measurements agree.
module clock_period_meter #(
   parameter int BW = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en_i,
   input  logic          sig_i,
   output logic [BW-1:0] max_val_o,
   output logic          valid_o,
   output logic          locked_o,
   output logic          timeout_o
);

   localparam logic [1:0]    ST_IDLE    = 2'd0;
   localparam logic [1:0]    ST_ARM     = 2'd1;
   localparam logic [1:0]    ST_MEASURE = 2'd2;
   localparam logic [BW:0]   CNT_ZERO   = '0;
   localparam logic [BW:0]   CNT_ONE    = {{BW{1'b0}}, 1'b1};
   localparam logic [BW:0]   CNT_MAX    = {1'b1, {BW{1'b0}}};
   localparam logic [BW-1:0] ONE_BW     = {{(BW-1){1'b0}}, 1'b1};

   logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [1:0]    state_q, state_d;
   logic [BW:0]   cnt_q, cnt_d;
   logic [BW:0]   prev_h_q, prev_h_d;
   logic          prev_vld_q, prev_vld_d;
   logic [BW-1:0] max_q, max_d;
   logic          valid_q, valid_d;
   logic          locked_q, locked_d;
   logic          timeout_q, timeout_d;
   logic          sig_edge;

   // Synchroniser free-runs in every state so leaving IDLE never sees a stale edge.
   assign sig_edge = s2_q ^ s3_q;

   always_comb begin
      s1_d       = sig_i;
      s2_d       = s1_q;
      s3_d       = s2_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      prev_h_d   = prev_h_q;
      prev_vld_d = prev_vld_q;
      max_d      = max_q;
      valid_d    = 1'b0;
      locked_d   = locked_q;
      timeout_d  = 1'b0;

      if (!en_i) begin
         state_d    = ST_IDLE;
         cnt_d      = CNT_ZERO;
         locked_d   = 1'b0;
         prev_vld_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARM;
               cnt_d   = CNT_ZERO;
            end
            ST_ARM: begin
               if (sig_edge) begin
                  state_d = ST_MEASURE;
                  cnt_d   = CNT_ONE;
               end
            end
            ST_MEASURE: begin
               // An edge on the terminal count is still a legal H = 2^BW measurement.
               if (sig_edge) begin
                  cnt_d      = CNT_ONE;
                  max_d      = cnt_q[BW-1:0] - ONE_BW;
                  valid_d    = 1'b1;
                  locked_d   = prev_vld_q && (prev_h_q == cnt_q);
                  prev_h_d   = cnt_q;
                  prev_vld_d = 1'b1;
               end else if (cnt_q == CNT_MAX) begin
                  state_d    = ST_ARM;
                  cnt_d      = CNT_ZERO;
                  timeout_d  = 1'b1;
                  locked_d   = 1'b0;
                  prev_vld_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         state_q    <= ST_IDLE;
         cnt_q      <= CNT_ZERO;
         prev_h_q   <= CNT_ZERO;
         prev_vld_q <= 1'b0;
         max_q      <= '0;
         valid_q    <= 1'b0;
         locked_q   <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prev_h_q   <= prev_h_d;
         prev_vld_q <= prev_vld_d;
         max_q      <= max_d;
         valid_q    <= valid_d;
         locked_q   <= locked_d;
         timeout_q  <= timeout_d;
      end
   end

   assign max_val_o = max_q;
   assign valid_o   = valid_q;
   assign locked_o  = locked_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: sig_i toggled with known half-periods, expected
// measurements queued per toggle and matched against each valid_o pulse.
module tb_clock_period_meter;

   typedef struct {
      int         half;
      int         toggles;
      logic [7:0] exp_max;
      logic       exp_locked;
   } vec_t;

   typedef struct {
      logic [7:0] max;
      logic       locked;
   } exp_t;

   logic       clk_i;
   logic       rst_i;
   logic       en_i;
   logic       sig_i;
   logic [7:0] max_val_o;
   logic       valid_o;
   logic       locked_o;
   logic       timeout_o;

   int   n_tests;
   int   n_fail;
   int   tmo_seen;
   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[5];

   // Bench-side view of the measurement history
   logic started;
   logic prev_ok;
   int   prev_h;

   clock_period_meter #(.BW(8)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i),
      .sig_i     (sig_i),
      .max_val_o (max_val_o),
      .valid_o   (valid_o),
      .locked_o  (locked_o),
      .timeout_o (timeout_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic void check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   always @(negedge clk_i) begin
      if (timeout_o) tmo_seen++;
      if (valid_o) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid: got max_val_o=%0d locked_o=%0d, expected no pulse",
                     max_val_o, locked_o);
         end else begin
            mon_e = sb_q.pop_front();
            check("valid_max_val", int'(max_val_o), int'(mon_e.max));
            check("valid_locked", int'(locked_o), int'(mon_e.locked));
         end
      end
   end

   // Each toggle after the first since arming closes a measurement of length p.
   task automatic run(input int p, input int n, input logic [7:0] emax);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         repeat (p) @(posedge clk_i);
         #1 sig_i = ~sig_i;
         if (!started) begin
            started = 1'b1;
         end else begin
            e.max    = emax;
            e.locked = prev_ok && (prev_h == p);
            sb_q.push_back(e);
            prev_h  = p;
            prev_ok = 1'b1;
         end
      end
   endtask

   task automatic enable_fresh();
      en_i  = 1'b0;
      sig_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      started = 1'b0;
      prev_ok = 1'b0;
      en_i    = 1'b1;
      repeat (4) @(posedge clk_i);
      #1;
   endtask

   task automatic drain(input string name);
      repeat (6) @(posedge clk_i);
      @(negedge clk_i);
      check(name, sb_q.size(), 0);
   endtask

   task automatic disable_en(input logic [7:0] hold_max);
      @(posedge clk_i);
      #1 en_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      check("en_drop_locked", int'(locked_o), 0);
      check("en_drop_max_hold", int'(max_val_o), int'(hold_max));
      sb_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int tmo0;
      n_tests  = 0;
      n_fail   = 0;
      tmo_seen = 0;
      started  = 1'b0;
      prev_ok  = 1'b0;
      prev_h   = 0;
      vecs[0] = '{4,   8,  8'd3,   1'b1};
      vecs[1] = '{1,   12, 8'd0,   1'b1};
      vecs[2] = '{2,   6,  8'd1,   1'b1};
      vecs[3] = '{7,   5,  8'd6,   1'b1};
      vecs[4] = '{256, 4,  8'd255, 1'b1};

      rst_i = 1'b1;
      en_i  = 1'b1;
      sig_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("reset_max_val", int'(max_val_o), 0);
      check("reset_valid", int'(valid_o), 0);
      check("reset_locked", int'(locked_o), 0);
      check("reset_timeout", int'(timeout_o), 0);
      rst_i = 1'b0;
      en_i  = 1'b0;

      for (int i = 0; i < 5; i++) begin
         enable_fresh();
         tmo0 = tmo_seen;
         run(vecs[i].half, vecs[i].toggles, vecs[i].exp_max);
         drain("vec_drained");
         check("vec_locked", int'(locked_o), int'(vecs[i].exp_locked));
         check("vec_max_val", int'(max_val_o), int'(vecs[i].exp_max));
         check("vec_no_timeout", tmo_seen, tmo0);
         disable_en(vecs[i].exp_max);
      end

      // Timeout after a 256-cycle half-period run, then re-arm from ARM
      enable_fresh();
      tmo0 = tmo_seen;
      run(256, 3, 8'd255);
      repeat (250) @(posedge clk_i);
      @(negedge clk_i);
      check("timeout_not_early", tmo_seen, tmo0);
      repeat (15) @(posedge clk_i);
      @(negedge clk_i);
      check("timeout_pulse", tmo_seen, tmo0 + 1);
      check("timeout_locked", int'(locked_o), 0);
      check("timeout_max_hold", int'(max_val_o), 255);
      check("timeout_drained", sb_q.size(), 0);
      started = 1'b0;
      prev_ok = 1'b0;
      run(4, 4, 8'd3);
      drain("rearm_drained");
      check("rearm_locked", int'(locked_o), 1);
      disable_en(8'd3);

      // Half-period change 4 -> 6 without a gap
      enable_fresh();
      run(4, 5, 8'd3);
      run(6, 3, 8'd5);
      drain("change_drained");
      check("change_locked", int'(locked_o), 1);
      check("change_max_val", int'(max_val_o), 5);
      disable_en(8'd5);

      // Reset mid-measurement, then relock
      enable_fresh();
      run(4, 6, 8'd3);
      repeat (5) @(posedge clk_i);
      @(negedge clk_i);
      check("pre_reset_locked", int'(locked_o), 1);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check("midrst_max_val", int'(max_val_o), 0);
      check("midrst_valid", int'(valid_o), 0);
      check("midrst_locked", int'(locked_o), 0);
      check("midrst_timeout", int'(timeout_o), 0);
      repeat (4) @(posedge clk_i);
      #1;
      started = 1'b0;
      prev_ok = 1'b0;
      run(4, 4, 8'd3);
      drain("post_reset_drained");
      check("post_reset_locked", int'(locked_o), 1);

      // Enable dropped while locked, then relock
      disable_en(8'd3);
      enable_fresh();
      run(4, 4, 8'd3);
      drain("reenable_drained");
      check("reenable_locked", int'(locked_o), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
